// File: rtl/width_packer_buffer_pkg.sv
// Shared defaults and sizing helpers for the narrow-to-wide packing buffer.
package width_packer_buffer_pkg;

  localparam int unsigned dflt_input_width  = 8;
  localparam int unsigned dflt_output_width = 32;
  localparam int unsigned dflt_buffer_width = 16;
  localparam int unsigned dflt_buffer_depth = 256;

  // Counter width able to index n slices; never narrower than one bit.
  function automatic int unsigned count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of storage macros needed to cover a word of the given width.
  function automatic int unsigned ebr_count(input int unsigned word_width,
                                            input int unsigned macro_width);
    return ((word_width - 1) / macro_width) + 1;
  endfunction

endpackage

// File: rtl/width_packer_buffer_if.sv
// Byte-in / packed-word-out bus of the packing buffer, with status flags.
interface width_packer_buffer_if
  import width_packer_buffer_pkg::*;
#(
  parameter int unsigned input_width  = dflt_input_width,
  parameter int unsigned output_width = dflt_output_width
);

  logic                    data_in_valid;
  logic [input_width-1:0]  data_in;
  logic                    flush;
  logic                    data_out_ready;
  logic                    data_out_valid;
  logic [output_width-1:0] data_out;
  logic                    full;
  logic                    overflow;

  modport master (
    output data_in_valid, data_in, flush, data_out_ready,
    input  data_out_valid, data_out, full, overflow
  );

  modport slave (
    input  data_in_valid, data_in, flush, data_out_ready,
    output data_out_valid, data_out, full, overflow
  );

endinterface

// File: rtl/ice40_ebr.sv
// Simple dual-port embedded block RAM: one write port, one registered read port.
module ice40_ebr #(
  parameter int unsigned data_width = 16,
  parameter int unsigned addr_width = 8
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  read_en,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  localparam int unsigned depth = 1 << addr_width;

  logic [data_width-1:0] mem [depth];

  // Contents are deliberately left unreset, matching the hard macro.
  always_ff @(posedge clock) begin
    if (write_en) mem[waddr] <= wdata;
    if (read_en)  rdata      <= mem[raddr];
  end

endmodule

// File: rtl/width_packer_buffer_byte_packer.sv
// Assembles narrow input words into one wide word, least-significant slice first,
// and emits a commit strobe on completion or on a flush of a partial word.
module width_packer_buffer_byte_packer
  import width_packer_buffer_pkg::*;
#(
  parameter int unsigned input_width  = dflt_input_width,
  parameter int unsigned output_width = dflt_output_width
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    data_in_valid,
  input  logic [input_width-1:0]  data_in,
  input  logic                    flush,
  output logic                    commit_valid,
  output logic [output_width-1:0] commit_word
);

  localparam int unsigned ratio     = output_width / input_width;
  localparam int unsigned cnt_width = count_width(ratio);
  localparam logic [cnt_width-1:0] last_slice = cnt_width'(ratio - 1);

  logic [cnt_width-1:0]    counter_q;
  logic [cnt_width-1:0]    counter_d;
  logic [output_width-1:0] assembly_q;
  logic [output_width-1:0] assembly_d;
  logic [output_width-1:0] merged;

  // Current byte is merged before any commit decision, so flush+valid keeps it.
  always_comb begin
    merged     = assembly_q;
    counter_d  = counter_q;
    assembly_d = assembly_q;
    for (int unsigned s = 0; s < ratio; s++) begin
      if (data_in_valid && (counter_q == cnt_width'(s))) begin
        merged[s*input_width +: input_width] = data_in;
      end
    end
    commit_valid = (data_in_valid && (counter_q == last_slice)) ||
                   (flush && (data_in_valid || (counter_q != '0)));
    commit_word  = merged;
    if (commit_valid) begin
      counter_d  = '0;
      assembly_d = '0;
    end else if (data_in_valid) begin
      counter_d  = counter_q + cnt_width'(1);
      assembly_d = merged;
    end
  end

  // Zeroed assembly means unfilled slices of a flushed word read as 0.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      counter_q  <= '0;
      assembly_q <= '0;
    end else begin
      counter_q  <= counter_d;
      assembly_q <= assembly_d;
    end
  end

endmodule

// File: rtl/width_packer_buffer.sv
// Packs narrow words into wide words, queues them in block RAM and presents
// them through a valid/ready output register.
module width_packer_buffer
  import width_packer_buffer_pkg::*;
#(
  parameter int unsigned input_width  = dflt_input_width,
  parameter int unsigned output_width = dflt_output_width,
  parameter int unsigned buffer_width = dflt_buffer_width,
  parameter int unsigned buffer_depth = dflt_buffer_depth
) (
  input  logic                 clock,
  input  logic                 nreset,
  width_packer_buffer_if.slave bus
);

  localparam int unsigned num_ebrs   = ebr_count(output_width, buffer_width);
  localparam int unsigned addr_width = $clog2(buffer_depth);
  localparam int unsigned ptr_width  = addr_width + 1;
  localparam int unsigned pad_width  = num_ebrs * buffer_width;

  logic                    commit_valid;
  logic [output_width-1:0] commit_word;

  logic [ptr_width-1:0]    wr_ptr;
  logic [ptr_width-1:0]    rd_ptr;
  logic [ptr_width-1:0]    count;
  logic                    read_pending;
  logic                    out_valid;
  logic [output_width-1:0] out_word;
  logic                    overflow_q;

  logic                    full_c;
  logic                    write_en_c;
  logic                    read_issue_c;
  logic [pad_width-1:0]    wdata_pad;
  logic [pad_width-1:0]    rdata_pad;

  width_packer_buffer_byte_packer #(
    .input_width  (input_width),
    .output_width (output_width)
  ) u_packer (
    .clock         (clock),
    .nreset        (nreset),
    .data_in_valid (bus.data_in_valid),
    .data_in       (bus.data_in),
    .flush         (bus.flush),
    .commit_valid  (commit_valid),
    .commit_word   (commit_word)
  );

  // Occupancy excludes the entry being written, so a read never collides with it.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    full_c       = (count == ptr_width'(buffer_depth));
    write_en_c   = commit_valid && !full_c;
    read_issue_c = (count != '0) && !read_pending &&
                   (!out_valid || bus.data_out_ready);
    wdata_pad    = '0;
    wdata_pad[output_width-1:0] = commit_word;
  end

  for (genvar e = 0; e < num_ebrs; e++) begin : g_ebr
    ice40_ebr #(
      .data_width (buffer_width),
      .addr_width (addr_width)
    ) u_ebr (
      .clock    (clock),
      .write_en (write_en_c),
      .waddr    (wr_ptr[addr_width-1:0]),
      .wdata    (wdata_pad[e*buffer_width +: buffer_width]),
      .read_en  (read_issue_c),
      .raddr    (rd_ptr[addr_width-1:0]),
      .rdata    (rdata_pad[e*buffer_width +: buffer_width])
    );
  end

  // FIFO pointers and sticky overflow for words committed into a full buffer.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (write_en_c)              wr_ptr     <= wr_ptr + ptr_width'(1);
      if (commit_valid && full_c)  overflow_q <= 1'b1;
      if (read_issue_c)            rd_ptr     <= rd_ptr + ptr_width'(1);
    end
  end

  // Output register: loads one cycle after a read issue, holds while stalled.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      read_pending <= 1'b0;
      out_valid    <= 1'b0;
      out_word     <= '0;
    end else begin
      read_pending <= read_issue_c;
      if (read_pending) begin
        out_valid <= 1'b1;
        out_word  <= rdata_pad[output_width-1:0];
      end else if (out_valid && bus.data_out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out_valid = out_valid;
  assign bus.data_out       = out_word;
  assign bus.full           = full_c;
  assign bus.overflow       = overflow_q;

endmodule
